// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and helpers for the data-SRAM access controller.
// Size/state encodings, request latch struct, strobe/write-data/alignment helpers.
package dmem_access_ctrl_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              sign;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic logic [NUM_LANES-1:0] gen_wstrb(input logic we, input logic [1:0] size,
                                                     input logic [1:0] lo);
    logic [NUM_LANES-1:0] s;
    if (!we)                s = 4'b0000;
    else if (size == SZ_B)  s = 4'b0001 << lo;
    else if (size == SZ_H)  s = lo[1] ? 4'b1100 : 4'b0011;
    else                    s = 4'b1111;
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] gen_wdata(input logic [1:0] size,
                                                  input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] w;
    if (size == SZ_B)      w = {4{d[7:0]}};
    else if (size == SZ_H) w = {2{d[15:0]}};
    else                   w = d;
    return w;
  endfunction

  // Half/word accesses always go out naturally aligned; low bits are dropped.
  function automatic logic [ADDR_W-1:0] align_addr(input logic [1:0] size,
                                                   input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    if (size == SZ_B)      r = a;
    else if (size == SZ_H) r = {a[ADDR_W-1:1], 1'b0};
    else                   r = {a[ADDR_W-1:2], 2'b00};
    return r;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_load_ext.sv
// Load-data lane select and sign/zero extension (purely combinational).
module dmem_load_ext
  import dmem_access_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              sign,
  output logic [DATA_W-1:0] data
);

  logic [NUM_LANES-1:0][LANE_W-1:0] lanes;
  logic [LANE_W-1:0]                b;
  logic [2*LANE_W-1:0]              h;

  assign lanes = rdata;

  always_comb begin
    b    = lanes[addr_lo];
    h    = addr_lo[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};
    data = rdata;
    case (size)
      SZ_B:    data = {{(DATA_W-LANE_W){sign & b[LANE_W-1]}}, b};
      SZ_H:    data = {{(DATA_W-2*LANE_W){sign & h[2*LANE_W-1]}}, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-SRAM access sequencer: req/addr_ok/data_ok handshake, strobes, load extension,
// optional watchdog (TIMEOUT_CYC>0) and optional misalignment abort (DMEM_ALIGN_CHECK_EN).
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  input  logic              flush,
  output logic              stallreq,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [3:0]        data_sram_wstrb,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [DATA_W-1:0] data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  output logic              load_valid,
  output logic [DATA_W-1:0] load_data,
  output logic              bus_err
);

  state_t            state, state_nxt;
  mem_req_t          op_q;
  logic              misalign, accept, in_flight, wd_expire;
  logic              err_nxt, lv_nxt;
  logic [DATA_W-1:0] ext_data;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = ((req_size == SZ_H) && req_addr[0]) ||
                    ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign accept    = (state == S_IDLE) && req_valid && !flush && !misalign;
  assign in_flight = (state == S_REQ) || (state == S_WAIT);

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    lv_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid && !flush) begin
          if (misalign) err_nxt   = 1'b1;
          else          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        // A handshake that lands in the expiry cycle wins over the watchdog.
        if (data_sram_addr_ok)  state_nxt = flush ? S_DRAIN : S_WAIT;
        else if (flush)         state_nxt = S_IDLE;
        else if (wd_expire) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end
      end
      S_WAIT: begin
        if (data_sram_data_ok) begin
          state_nxt = S_IDLE;
          lv_nxt    = !flush && !op_q.we;
        end else if (flush) begin
          state_nxt = S_DRAIN;
        end else if (wd_expire) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (data_sram_data_ok) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready       = (state == S_IDLE);
    stallreq        = (state == S_IDLE) ? (req_valid && !misalign) : 1'b1;
    data_sram_req   = (state == S_REQ);
    data_sram_wr    = data_sram_req && op_q.we;
    data_sram_size  = data_sram_req ? op_q.size : 2'b00;
    data_sram_addr  = data_sram_req ? op_q.addr : '0;
    data_sram_wstrb = data_sram_req ? gen_wstrb(op_q.we, op_q.size, op_q.addr[1:0]) : 4'b0000;
    data_sram_wdata = (data_sram_req && op_q.we) ? gen_wdata(op_q.size, op_q.wdata) : '0;
  end

  dmem_load_ext u_load_ext (
    .rdata   (data_sram_rdata),
    .addr_lo (op_q.addr[1:0]),
    .size    (op_q.size),
    .sign    (op_q.sign),
    .data    (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= '0;
      load_valid <= 1'b0;
      load_data  <= '0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      load_valid <= lv_nxt;
      bus_err    <= err_nxt;
      if (accept) begin
        op_q.we    <= req_we;
        op_q.size  <= req_size;
        op_q.sign  <= req_sign;
        op_q.addr  <= align_addr(req_size, req_addr);
        op_q.wdata <= req_wdata;
      end
      if (lv_nxt) load_data <= ext_data;
    end
  end

  generate
    if (TIMEOUT_CYC > 0) begin : g_wdog
      localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
      localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);
      logic [CW-1:0] cnt;

      // Saturates so a late handshake at expiry cannot wrap and reopen the window.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                          cnt <= '0;
        else if (accept)                  cnt <= '0;
        else if (in_flight && cnt != CNT_MAX) cnt <= cnt + CW'(1);
      end

      assign wd_expire = in_flight && (cnt == CNT_MAX);
    end else begin : g_nowdog
      assign wd_expire = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl (TIMEOUT_CYC=8).
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_sign, flush;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, stallreq;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        load_valid;
  logic [31:0] load_data;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_we            (req_we),
    .req_size          (req_size),
    .req_sign          (req_sign),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_ready         (req_ready),
    .flush             (flush),
    .stallreq          (stallreq),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .load_valid        (load_valid),
    .load_data         (load_data),
    .bus_err           (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_size = sz; req_sign = sg;
    req_addr = a; req_wdata = wd;
  endtask

  // Load with immediate addr_ok and data_ok one cycle later.
  task automatic quick_load(input string tag, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] rd, input logic [31:0] exp);
    issue(1'b0, sz, sg, a, 32'h0);
    step;
    req_valid = 1'b0;
    data_sram_addr_ok = 1'b1;
    step;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd;
    step;
    data_sram_data_ok = 1'b0;
    chk({tag, "_lv"}, {31'b0, load_valid}, 32'd1);
    chk({tag, "_data"}, load_data, exp);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sign = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; flush = 1'b0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    step; step;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_stall", {31'b0, stallreq}, 32'd0);
    chk("rst_req",   {31'b0, data_sram_req}, 32'd0);
    chk("rst_lv",    {31'b0, load_valid}, 32'd0);
    chk("rst_err",   {31'b0, bus_err}, 32'd0);
    chk("rst_addr",  data_sram_addr, 32'h0);
    rst = 1'b0;
    step;

    // lb 0x1003 signed, data_ok two cycles after addr_ok
    issue(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0);
    #1;
    chk("lb_idle_stall", {31'b0, stallreq}, 32'd1);
    step;
    req_valid = 1'b0;
    chk("lb_req",   {31'b0, data_sram_req}, 32'd1);
    chk("lb_addr",  data_sram_addr, 32'h0000_1003);
    chk("lb_wr",    {31'b0, data_sram_wr}, 32'd0);
    chk("lb_wstrb", {28'b0, data_sram_wstrb}, 32'h0);
    chk("lb_ready", {31'b0, req_ready}, 32'd0);
    data_sram_addr_ok = 1'b1;
    step;
    data_sram_addr_ok = 1'b0;
    chk("lb_wait_req",   {31'b0, data_sram_req}, 32'd0);
    chk("lb_wait_stall", {31'b0, stallreq}, 32'd1);
    step;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_FFFF;
    #1;
    chk("lb_dok_stall", {31'b0, stallreq}, 32'd1);
    step;
    data_sram_data_ok = 1'b0;
    chk("lb_lv",    {31'b0, load_valid}, 32'd1);
    chk("lb_data",  load_data, 32'hFFFF_FF80);
    chk("lb_stall", {31'b0, stallreq}, 32'd0);
    step;
    chk("lb_lv_pulse", {31'b0, load_valid}, 32'd0);

    // sh 0x2002
    issue(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_BEEF);
    step;
    req_valid = 1'b0;
    chk("sh_wr",    {31'b0, data_sram_wr}, 32'd1);
    chk("sh_wstrb", {28'b0, data_sram_wstrb}, 32'hC);
    chk("sh_wdata", data_sram_wdata, 32'hBEEF_BEEF);
    chk("sh_size",  {30'b0, data_sram_size}, 32'd1);
    data_sram_addr_ok = 1'b1;
    step;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1;
    step;
    data_sram_data_ok = 1'b0;
    chk("sh_no_lv", {31'b0, load_valid}, 32'd0);
    chk("sh_ready", {31'b0, req_ready}, 32'd1);

    // sb lane 1 strobe/replication
    issue(1'b1, 2'd0, 1'b0, 32'h0000_2101, 32'h0000_005A);
    step;
    req_valid = 1'b0;
    chk("sb_wstrb", {28'b0, data_sram_wstrb}, 32'h2);
    chk("sb_wdata", data_sram_wdata, 32'h5A5A_5A5A);
    data_sram_addr_ok = 1'b1;
    step;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1;
    step;
    data_sram_data_ok = 1'b0;

    // lw with addr_ok stalled three cycles
    issue(1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'h0);
    step;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lw_hold_req",   {31'b0, data_sram_req}, 32'd1);
      chk("lw_hold_addr",  data_sram_addr, 32'h0000_3000);
      chk("lw_hold_stall", {31'b0, stallreq}, 32'd1);
      step;
    end
    data_sram_addr_ok = 1'b1;
    chk("lw_req4", {31'b0, data_sram_req}, 32'd1);
    step;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1234_5678;
    #1;
    chk("lw_dok_stall", {31'b0, stallreq}, 32'd1);
    step;
    data_sram_data_ok = 1'b0;
    chk("lw_lv",    {31'b0, load_valid}, 32'd1);
    chk("lw_data",  load_data, 32'h1234_5678);
    chk("lw_stall", {31'b0, stallreq}, 32'd0);

    // extension variants
    quick_load("lh",  2'd1, 1'b1, 32'h0000_6002, 32'h8001_7FFF, 32'hFFFF_8001);
    quick_load("lhu", 2'd1, 1'b0, 32'h0000_6000, 32'h1234_FEDC, 32'h0000_FEDC);
    quick_load("lbu", 2'd0, 1'b0, 32'h0000_7001, 32'h0000_A500, 32'h0000_00A5);

    // flush in S_WAIT, data_ok two cycles later
    issue(1'b0, 2'd1, 1'b0, 32'h0000_4002, 32'h0);
    step;
    req_valid = 1'b0;
    data_sram_addr_ok = 1'b1;
    step;
    data_sram_addr_ok = 1'b0;
    flush = 1'b1;
    step;
    flush = 1'b0;
    chk("fl_drain_ready", {31'b0, req_ready}, 32'd0);
    chk("fl_drain_stall", {31'b0, stallreq}, 32'd1);
    chk("fl_drain_req",   {31'b0, data_sram_req}, 32'd0);
    step;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    chk("fl_dok_ready", {31'b0, req_ready}, 32'd0);
    step;
    data_sram_data_ok = 1'b0;
    chk("fl_no_lv", {31'b0, load_valid}, 32'd0);
    chk("fl_ready", {31'b0, req_ready}, 32'd1);

    // flush in S_REQ without addr_ok drops the request
    issue(1'b0, 2'd2, 1'b0, 32'h0000_4100, 32'h0);
    step;
    req_valid = 1'b0;
    flush = 1'b1;
    step;
    flush = 1'b0;
    chk("flreq_ready", {31'b0, req_ready}, 32'd1);
    chk("flreq_req",   {31'b0, data_sram_req}, 32'd0);

    // flush coincident with data_ok: discarded, no pulse
    issue(1'b0, 2'd0, 1'b0, 32'h0000_4200, 32'h0);
    step;
    req_valid = 1'b0;
    data_sram_addr_ok = 1'b1;
    step;
    data_sram_addr_ok = 1'b0;
    flush = 1'b1;
    data_sram_data_ok = 1'b1;
    step;
    flush = 1'b0;
    data_sram_data_ok = 1'b0;
    chk("fldok_no_lv", {31'b0, load_valid}, 32'd0);
    chk("fldok_ready", {31'b0, req_ready}, 32'd1);

    // watchdog: addr_ok never arrives
    issue(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0);
    step;
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("wd_req_held", {31'b0, data_sram_req}, 32'd1);
      chk("wd_no_err",   {31'b0, bus_err}, 32'd0);
      step;
    end
    chk("wd_err",   {31'b0, bus_err}, 32'd1);
    chk("wd_ready", {31'b0, req_ready}, 32'd1);
    chk("wd_req",   {31'b0, data_sram_req}, 32'd0);
    step;
    chk("wd_err_pulse", {31'b0, bus_err}, 32'd0);

    // misaligned word
    issue(1'b0, 2'd2, 1'b0, 32'h0000_1002, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
    #1;
    chk("mis_stall", {31'b0, stallreq}, 32'd0);
    step;
    req_valid = 1'b0;
    chk("mis_err",   {31'b0, bus_err}, 32'd1);
    chk("mis_req",   {31'b0, data_sram_req}, 32'd0);
    chk("mis_ready", {31'b0, req_ready}, 32'd1);
    step;
    chk("mis_err_pulse", {31'b0, bus_err}, 32'd0);
    chk("mis_req2",      {31'b0, data_sram_req}, 32'd0);
`else
    step;
    req_valid = 1'b0;
    chk("mis_req",  {31'b0, data_sram_req}, 32'd1);
    chk("mis_addr", data_sram_addr, 32'h0000_1000);
    chk("mis_err",  {31'b0, bus_err}, 32'd0);
    data_sram_addr_ok = 1'b1;
    step;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFE_F00D;
    step;
    data_sram_data_ok = 1'b0;
    chk("mis_data", load_data, 32'hCAFE_F00D);
`endif

    // reset mid-access
    issue(1'b0, 2'd2, 1'b0, 32'h0000_8000, 32'h0);
    step;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstmid_ready", {31'b0, req_ready}, 32'd1);
    chk("rstmid_req",   {31'b0, data_sram_req}, 32'd0);
    step;
    rst = 1'b0;
    chk("rstmid_lv",  {31'b0, load_valid}, 32'd0);
    chk("rstmid_err", {31'b0, bus_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
